ucsbece154_sdram_rdctrl: RTL and testbench

UCSBECE154_SDRAM_RDCTRL -- requirements
Module: ucsbece154_sdram_rdctrl

---
 rtl/ucsbece154_mem_pkg.sv | 20 ++
 rtl/ucsbece154_sdram_rdctrl_if.sv | 20 ++
 rtl/ucsbece154_sdram_array.sv | 21 ++
 rtl/ucsbece154_sdram_rdctrl.sv | 90 +++++++++
 tb/tb_ucsbece154_sdram_rdctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ucsbece154_mem_pkg.sv
// Shared memory-side definitions: read-controller state encoding and the
// default burst geometry/latency constants the cache is built against.
package ucsbece154_mem_pkg;

  localparam int BLOCK_WORDS_DEF = 4;
  localparam int T0_DELAY_DEF    = 40;
  localparam int T_DELAY_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    BURST      = 2'd2,
    REARM      = 2'd3
  } rd_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ucsbece154_sdram_rdctrl_if.sv
// Cache <-> SDRAM read-controller bus, plus the backing-store write port.
interface ucsbece154_sdram_rdctrl_if;
  logic [31:0] MemReadAddress;
  logic        MemReadRequest;
  logic [31:0] MemDataIn;
  logic        MemDataReady;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;

  modport master (
    output MemReadAddress, MemReadRequest, WriteEnable, WriteAddress, WriteData,
    input  MemDataIn, MemDataReady
  );

  modport slave (
    input  MemReadAddress, MemReadRequest, WriteEnable, WriteAddress, WriteData,
    output MemDataIn, MemDataReady
  );
endinterface

// File: rtl/ucsbece154_sdram_array.sv
// MEM_WORDS x 32 backing store: one synchronous write port, one async read port.
module ucsbece154_sdram_array #(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr_i,
  input  logic [31:0]                  wdata_i,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr_i,
  output logic [31:0]                  rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ucsbece154_sdram_rdctrl.sv
// SDRAM read-burst model: fixed first-word latency, fixed inter-word spacing,
// block-aligned ascending bursts, abort on request drop, rearm on request low.
module ucsbece154_sdram_rdctrl
  import ucsbece154_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int MEM_WORDS   = 1024,
  parameter int T0_DELAY    = T0_DELAY_DEF,
  parameter int T_DELAY     = T_DELAY_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  ucsbece154_sdram_rdctrl_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int CW = $clog2(max2(T0_DELAY, T_DELAY) + 1);
  localparam int BW = AW - WW;

  localparam logic [CW-1:0] T0_LOAD   = CW'(T0_DELAY - 1);
  localparam logic [CW-1:0] T_LOAD    = CW'(T_DELAY - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_WORDS - 1);

  rd_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [WW-1:0] wcnt_q;
  logic [WW-1:0] rd_word_q;
  logic [BW-1:0] base_q;
  logic          rdy_q;
  logic [31:0]   rdata;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      rd_word_q <= '0;
      base_q    <= '0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.MemReadRequest) begin
            base_q  <= bus.MemReadAddress[AW+1:WW+2];
            cnt_q   <= T0_LOAD;
            wcnt_q  <= '0;
            state_q <= WAIT_FIRST;
          end
        end
        WAIT_FIRST, BURST: begin
          if (cnt_q == '0) begin
            rdy_q     <= 1'b1;
            rd_word_q <= wcnt_q;
            wcnt_q    <= wcnt_q + 1'b1;
            cnt_q     <= T_LOAD;
            state_q   <= (wcnt_q == LAST_WORD) ? REARM : BURST;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
          // a word firing on this edge is still delivered; only later ones are dropped
          if (!bus.MemReadRequest) state_q <= IDLE;
        end
        REARM: begin
          if (!bus.MemReadRequest) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // read happens in the delivery cycle, so writes landed on earlier edges are seen
  ucsbece154_sdram_array #(.MEM_WORDS(MEM_WORDS)) u_array (
    .clk_i   (Clk),
    .we_i    (bus.WriteEnable & ~Reset),
    .waddr_i (bus.WriteAddress[AW+1:2]),
    .wdata_i (bus.WriteData),
    .raddr_i ({base_q, rd_word_q}),
    .rdata_o (rdata)
  );

  assign bus.MemDataReady = rdy_q;
  assign bus.MemDataIn    = rdy_q ? rdata : 32'd0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.MemReadAddress[31:AW+2], bus.MemReadAddress[WW+1:0],
                              bus.WriteAddress[31:AW+2], bus.WriteAddress[1:0]};

endmodule

// File: tb/tb_ucsbece154_sdram_rdctrl.sv
// Randomized + directed bench for the SDRAM read controller against a
// timing-arithmetic reference model (T0_DELAY=4, T_DELAY=1, BLOCK_WORDS=4).
module tb_ucsbece154_sdram_rdctrl;

  localparam int BW = 4;
  localparam int T0 = 4;
  localparam int TD = 1;
  localparam int MW = 1024;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  ucsbece154_sdram_rdctrl_if bus();

  ucsbece154_sdram_rdctrl #(
    .BLOCK_WORDS (BW),
    .MEM_WORDS   (MW),
    .T0_DELAY    (T0),
    .T_DELAY     (TD)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: a burst is a start edge plus arithmetic on elapsed edges
  logic [31:0] mmem [MW];
  int          ecnt    = 0;
  int          t_acc   = 0;
  bit          busy    = 0;
  bit          rearm   = 0;
  bit          started = 0;
  bit          erdy    = 0;
  logic [9:0]  base_idx = '0;
  logic [9:0]  eidx     = '0;

  always @(posedge Clk) begin
    int j;
    erdy = 0;
    if (Reset) begin
      busy = 0;
      rearm = 0;
      started = 1;
    end else begin
      if (busy) begin
        j = ecnt - t_acc - T0;
        if (j >= 0 && (j % TD) == 0 && (j / TD) < BW) begin
          erdy = 1;
          eidx = base_idx + 10'(j / TD);
          if ((j / TD) == BW - 1) begin
            busy  = 0;
            rearm = bus.MemReadRequest;
          end
        end
        if (!bus.MemReadRequest) busy = 0;
      end else if (rearm) begin
        if (!bus.MemReadRequest) rearm = 0;
      end else if (bus.MemReadRequest) begin
        busy     = 1;
        t_acc    = ecnt;
        base_idx = bus.MemReadAddress[11:2] & ~10'(BW - 1);
      end
      if (bus.WriteEnable) mmem[bus.WriteAddress[11:2]] = bus.WriteData;
    end
    ecnt++;
  end

  logic [31:0] cap_d[$];
  int          cap_e[$];

  always @(negedge Clk) begin
    logic [31:0] expd;
    if (started) begin
      expd = erdy ? mmem[eidx] : 32'd0;
      checks++;
      if (bus.MemDataReady !== erdy) begin
        errors++;
        $display("FAIL ready @edge %0d act=%b exp=%b", ecnt - 1, bus.MemDataReady, erdy);
      end
      checks++;
      if (bus.MemDataIn !== expd) begin
        errors++;
        $display("FAIL data @edge %0d act=%h exp=%h", ecnt - 1, bus.MemDataIn, expd);
      end
    end
    if (bus.MemDataReady === 1'b1) begin
      cap_d.push_back(bus.MemDataIn);
      cap_e.push_back(ecnt - 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.WriteEnable  = 1'b1;
    bus.WriteAddress = a;
    bus.WriteData    = d;
    tick();
    bus.WriteEnable  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.MemReadRequest = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clr();
    cap_d.delete();
    cap_e.delete();
  endtask

  task automatic start(input logic [31:0] a, output int acc);
    bus.MemReadAddress = a;
    bus.MemReadRequest = 1'b1;
    acc = ecnt;
  endtask

  task automatic chk_block(input string name, input int acc, input logic [31:0] d0);
    chk({name, "_count"}, cap_d.size(), 4);
    if (cap_d.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk({name, "_edge"}, cap_e[k], acc + T0 + k * TD);
        chk({name, "_word"}, cap_d[k], d0 + k);
      end
  endtask

  initial begin
    int acc;
    Reset = 1'b1;
    bus.MemReadAddress = '0;
    bus.MemReadRequest = 1'b0;
    bus.WriteEnable    = 1'b0;
    bus.WriteAddress   = '0;
    bus.WriteData      = '0;
    tick();
    tick();
    chk("reset_ready", bus.MemDataReady, 0);
    chk("reset_data", bus.MemDataIn, 0);
    Reset = 1'b0;

    for (int i = 0; i < MW; i++) wr(32'(i * 4), $urandom);
    for (int i = 0; i < 4; i++) wr(32'h40 + 32'(i * 4), 32'hA0 + 32'(i));
    wr(32'h0, 32'h12345678);
    tick();

    // aligned ascending burst, then held request must not retrigger
    clr();
    start(32'h48, acc);
    repeat (10) tick();
    chk_block("basic", acc, 32'hA0);
    repeat (5) tick();
    chk("no_fifth", cap_d.size(), 4);
    bus.MemReadRequest = 1'b0;
    tick();
    clr();
    start(32'h48, acc);
    repeat (6) tick();
    chk("rearm_edge", (cap_e.size() > 0) ? cap_e[0] : -1, acc + T0);
    idle(8);

    // early drop: nothing delivered; next request pays full latency
    clr();
    start(32'h40, acc);
    repeat (3) tick();
    idle(8);
    chk("abort_none", cap_d.size(), 0);
    start(32'h80, acc);
    repeat (6) tick();
    chk("after_abort_edge", (cap_e.size() > 0) ? cap_e[0] : -1, acc + T0);
    chk("after_abort_data", (cap_d.size() > 0) ? cap_d[0] : 32'hx, mmem[32]);
    idle(8);

    // reset mid-burst, with an ignored write during reset
    clr();
    start(32'h40, acc);
    repeat (6) tick();
    Reset = 1'b1;
    bus.WriteEnable  = 1'b1;
    bus.WriteAddress = 32'h40;
    bus.WriteData    = 32'hBAD0BAD0;
    tick();
    chk("rst_mid_ready", bus.MemDataReady, 0);
    chk("rst_mid_data", bus.MemDataIn, 0);
    Reset = 1'b0;
    bus.WriteEnable = 1'b0;
    idle(1);
    chk("rst_mid_count", cap_d.size(), 2);
    clr();
    start(32'h4C, acc);
    repeat (10) tick();
    chk_block("post_rst", acc, 32'hA0);
    idle(8);

    // write visibility relative to the delivery cycle
    clr();
    start(32'h40, acc);
    tick();
    tick();
    wr(32'h44, 32'hDEADBEEF);
    repeat (4) tick();
    wr(32'h48, 32'h11111111);
    repeat (3) tick();
    idle(8);
    chk("wr_count", cap_d.size(), 4);
    chk("wr_before", (cap_d.size() > 1) ? cap_d[1] : 32'hx, 32'hDEADBEEF);
    chk("wr_same_cycle", (cap_d.size() > 2) ? cap_d[2] : 32'hx, 32'hA2);

    // address wrap modulo MEM_WORDS*4
    clr();
    start(32'h1000, acc);
    repeat (6) tick();
    idle(8);
    chk("wrap_data", (cap_d.size() > 0) ? cap_d[0] : 32'hx, 32'h12345678);
    chk("wrap_edge", (cap_e.size() > 0) ? cap_e[0] : -1, acc + T0);

    // random traffic: request toggling, address churn, writes, occasional reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) bus.MemReadRequest = ~bus.MemReadRequest;
      bus.MemReadAddress = $urandom;
      bus.WriteEnable    = ($urandom_range(2) == 0);
      bus.WriteAddress   = $urandom;
      bus.WriteData      = $urandom;
      Reset              = ($urandom_range(299) == 0);
      tick();
    end
    Reset = 1'b0;
    bus.WriteEnable = 1'b0;
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
